// File: rtl/lsu_ecc_wb_ctl.sv
// LSU ECC write-back controller: captures single-bit-corrected DCCM bank words
// in DC3, qualifies them at DC4, queues them and arbitrates the single DCCM
// write port against store-buffer drain with starvation protection.
// Optional write-back counter enabled by defining LSU_ECC_WB_CNT_EN.
module lsu_ecc_wb_ctl #(
    parameter int unsigned DCCM_BITS  = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 single_ecc_error_hi_dc3,
    input  logic                 single_ecc_error_lo_dc3,
    input  logic                 lsu_double_ecc_error_dc3,
    input  logic [DCCM_BITS-1:0] lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0] end_addr_dc3,
    input  logic [DATA_W-1:0]    store_ecc_datafn_hi_dc3,
    input  logic [DATA_W-1:0]    store_ecc_datafn_lo_dc3,
    input  logic                 dec_tlu_core_ecc_disable,
    input  logic                 flush_dc4,
    input  logic                 stbuf_drain_req,
`ifdef LSU_ECC_WB_CNT_EN
    input  logic                 ecc_wb_count_clr,
    output logic [15:0]          ecc_wb_count,
`endif
    output logic                 stbuf_drain_gnt,
    output logic                 ecc_wr_en,
    output logic [DCCM_BITS-1:0] ecc_wr_addr,
    output logic [DATA_W-1:0]    ecc_wr_data,
    output logic                 ecc_wb_busy,
    output logic                 ecc_wb_ovf
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    // One-hot-style encoding: bit 0 drives ecc_wr_en, bit 1 drives stbuf_drain_gnt.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ECC   = 2'b01,
        ST_STBUF = 2'b10
    } arb_state_e;

    arb_state_e           state_q, nxt_state;

    logic                 dc4_lo_v, dc4_hi_v;
    logic [DCCM_BITS-1:0] dc4_lo_addr, dc4_hi_addr;
    logic [DATA_W-1:0]    dc4_lo_data, dc4_hi_data;

    logic [DCCM_BITS-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0]    fifo_data [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W-1:0]     fifo_cnt, free_cnt, req_cnt, acc_cnt;
    logic [IDX_W-1:0]     wr_idx, wr_idx_p1, rd_idx;

    logic                 lo_v4, hi_v4, fifo_empty, work_avail, pop, drop;
    logic [DCCM_BITS-1:0] head_addr, enq0_addr, wr_addr_nxt;
    logic [DATA_W-1:0]    head_data, enq0_data, wr_data_nxt;
    logic [SC_W-1:0]      starve_cnt, starve_nxt;
    logic                 busy_nxt, ovf_nxt;
    logic                 unused_addr_lsbs;

    // Byte offsets are discarded: writes are word aligned.
    assign unused_addr_lsbs = ^{lsu_addr_dc3[1:0], end_addr_dc3[1:0]};

    // DC3 -> DC4 capture of qualified corrections.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dc4_lo_v    <= 1'b0;
            dc4_hi_v    <= 1'b0;
            dc4_lo_addr <= '0;
            dc4_hi_addr <= '0;
            dc4_lo_data <= '0;
            dc4_hi_data <= '0;
        end else begin
            dc4_lo_v    <= single_ecc_error_lo_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
            dc4_hi_v    <= single_ecc_error_hi_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
            dc4_lo_addr <= {lsu_addr_dc3[DCCM_BITS-1:2], 2'b00};
            dc4_hi_addr <= {end_addr_dc3[DCCM_BITS-1:2], 2'b00};
            dc4_lo_data <= store_ecc_datafn_lo_dc3;
            dc4_hi_data <= store_ecc_datafn_hi_dc3;
        end
    end

    // Queue view: FIFO contents followed by surviving DC4 entries (bypass when empty).
    always_comb begin
        lo_v4      = dc4_lo_v & ~flush_dc4;
        hi_v4      = dc4_hi_v & ~flush_dc4;
        fifo_cnt   = wr_ptr - rd_ptr;
        fifo_empty = (wr_ptr == rd_ptr);
        work_avail = ~fifo_empty | lo_v4 | hi_v4;
        rd_idx     = rd_ptr[IDX_W-1:0];
        wr_idx     = wr_ptr[IDX_W-1:0];
        wr_idx_p1  = wr_idx + IDX_W'(1);
        enq0_addr  = lo_v4 ? dc4_lo_addr : dc4_hi_addr;
        enq0_data  = lo_v4 ? dc4_lo_data : dc4_hi_data;
        head_addr  = enq0_addr;
        head_data  = enq0_data;
        if (!fifo_empty) begin
            head_addr = fifo_addr[rd_idx];
            head_data = fifo_data[rd_idx];
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= nxt_state;
        end
    end

    // Next-state: who owns the write port next cycle.
    always_comb begin
        nxt_state = ST_IDLE;
        if (!work_avail) begin
            if (stbuf_drain_req) begin
                nxt_state = ST_STBUF;
            end
        end else if (stbuf_drain_req && (starve_cnt == SC_W'(STARVE_MAX))) begin
            nxt_state = ST_STBUF;
        end else begin
            nxt_state = ST_ECC;
        end
    end

    // Output/datapath next values: pop, enqueue acceptance, starvation, held write bus.
    always_comb begin
        pop         = (nxt_state == ST_ECC);
        free_cnt    = PTR_W'(DEPTH) - fifo_cnt + PTR_W'(pop);
        req_cnt     = PTR_W'(lo_v4) + PTR_W'(hi_v4);
        drop        = (req_cnt > free_cnt);
        acc_cnt     = drop ? free_cnt : req_cnt;
        starve_nxt  = starve_cnt;
        if (!stbuf_drain_req || (nxt_state == ST_STBUF)) begin
            starve_nxt = '0;
        end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
            starve_nxt = starve_cnt + SC_W'(1);
        end
        wr_addr_nxt = pop ? head_addr : ecc_wr_addr;
        wr_data_nxt = pop ? head_data : ecc_wr_data;
        busy_nxt    = ~fifo_empty | dc4_lo_v | dc4_hi_v;
        ovf_nxt     = ecc_wb_ovf | drop;
    end

    // FIFO storage; validity is tracked by the pointers only.
    always_ff @(posedge clk) begin
        if (acc_cnt != '0) begin
            fifo_addr[wr_idx] <= enq0_addr;
            fifo_data[wr_idx] <= enq0_data;
        end
        if (acc_cnt == PTR_W'(2)) begin
            fifo_addr[wr_idx_p1] <= dc4_hi_addr;
            fifo_data[wr_idx_p1] <= dc4_hi_data;
        end
    end

    // Pointers, starvation counter and registered outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            starve_cnt  <= '0;
            ecc_wr_addr <= '0;
            ecc_wr_data <= '0;
            ecc_wb_busy <= 1'b0;
            ecc_wb_ovf  <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + acc_cnt;
            rd_ptr      <= rd_ptr + PTR_W'(pop);
            starve_cnt  <= starve_nxt;
            ecc_wr_addr <= wr_addr_nxt;
            ecc_wr_data <= wr_data_nxt;
            ecc_wb_busy <= busy_nxt;
            ecc_wb_ovf  <= ovf_nxt;
        end
    end

    assign ecc_wr_en       = state_q[0];
    assign stbuf_drain_gnt = state_q[1];

`ifdef LSU_ECC_WB_CNT_EN
    // Saturating count of correction writes; clear wins over increment.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ecc_wb_count <= '0;
        end else if (ecc_wb_count_clr) begin
            ecc_wb_count <= '0;
        end else if (ecc_wr_en && (ecc_wb_count != 16'hFFFF)) begin
            ecc_wb_count <= ecc_wb_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ecc_wb_ctl.sv
// Self-checking bench for lsu_ecc_wb_ctl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_lsu_ecc_wb_ctl;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst_l;
    logic        single_ecc_error_hi_dc3;
    logic        single_ecc_error_lo_dc3;
    logic        lsu_double_ecc_error_dc3;
    logic [15:0] lsu_addr_dc3;
    logic [15:0] end_addr_dc3;
    logic [31:0] store_ecc_datafn_hi_dc3;
    logic [31:0] store_ecc_datafn_lo_dc3;
    logic        dec_tlu_core_ecc_disable;
    logic        flush_dc4;
    logic        stbuf_drain_req;
    logic        stbuf_drain_gnt;
    logic        ecc_wr_en;
    logic [15:0] ecc_wr_addr;
    logic [31:0] ecc_wr_data;
    logic        ecc_wb_busy;
    logic        ecc_wb_ovf;
`ifdef LSU_ECC_WB_CNT_EN
    logic        ecc_wb_count_clr;
    logic [15:0] ecc_wb_count;
    logic [15:0] e_cnt;
`endif

    lsu_ecc_wb_ctl #(
        .DCCM_BITS (16),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .single_ecc_error_hi_dc3 (single_ecc_error_hi_dc3),
        .single_ecc_error_lo_dc3 (single_ecc_error_lo_dc3),
        .lsu_double_ecc_error_dc3(lsu_double_ecc_error_dc3),
        .lsu_addr_dc3            (lsu_addr_dc3),
        .end_addr_dc3            (end_addr_dc3),
        .store_ecc_datafn_hi_dc3 (store_ecc_datafn_hi_dc3),
        .store_ecc_datafn_lo_dc3 (store_ecc_datafn_lo_dc3),
        .dec_tlu_core_ecc_disable(dec_tlu_core_ecc_disable),
        .flush_dc4               (flush_dc4),
        .stbuf_drain_req         (stbuf_drain_req),
`ifdef LSU_ECC_WB_CNT_EN
        .ecc_wb_count_clr        (ecc_wb_count_clr),
        .ecc_wb_count            (ecc_wb_count),
`endif
        .stbuf_drain_gnt         (stbuf_drain_gnt),
        .ecc_wr_en               (ecc_wr_en),
        .ecc_wr_addr             (ecc_wr_addr),
        .ecc_wr_data             (ecc_wr_data),
        .ecc_wb_busy             (ecc_wb_busy),
        .ecc_wb_ovf              (ecc_wb_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: pending queue, last DC3 captures, starvation count.
    ent_t        mq[$];
    ent_t        dc4q[$];
    int          starve;
    logic        e_wr_en, e_gnt, e_busy, e_ovf;
    logic [15:0] e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        dc4q.delete();
        starve  = 0;
        e_wr_en = 1'b0;
        e_gnt   = 1'b0;
        e_busy  = 1'b0;
        e_ovf   = 1'b0;
        e_addr  = '0;
        e_data  = '0;
`ifdef LSU_ECC_WB_CNT_EN
        e_cnt   = '0;
`endif
    endtask

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_step();
        ent_t pend[$];
        ent_t e;
        int   qn0, free;
        bit   do_ecc, do_gnt, drop;
        if (!flush_dc4) begin
            foreach (dc4q[i]) pend.push_back(dc4q[i]);
        end
        qn0    = mq.size();
        do_ecc = 0;
        do_gnt = 0;
        if (qn0 + pend.size() == 0) do_gnt = stbuf_drain_req;
        else if (stbuf_drain_req && starve == STARVE_MAX) do_gnt = 1;
        else do_ecc = 1;
        free = DEPTH - qn0 + (do_ecc ? 1 : 0);
        drop = 0;
        foreach (pend[i]) begin
            if (i < free) mq.push_back(pend[i]);
            else drop = 1;
        end
`ifdef LSU_ECC_WB_CNT_EN
        if (ecc_wb_count_clr) e_cnt = '0;
        else if (e_wr_en && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
        e_busy = (qn0 > 0) || (dc4q.size() > 0);
        if (do_ecc) begin
            e = mq.pop_front();
            e_addr = e.a;
            e_data = e.d;
        end
        e_wr_en = do_ecc;
        e_gnt   = do_gnt;
        e_ovf   = e_ovf | drop;
        if (!stbuf_drain_req || do_gnt) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        dc4q.delete();
        if (!lsu_double_ecc_error_dc3 && !dec_tlu_core_ecc_disable) begin
            if (single_ecc_error_lo_dc3) begin
                e.a = lsu_addr_dc3 & 16'hFFFC;
                e.d = store_ecc_datafn_lo_dc3;
                dc4q.push_back(e);
            end
            if (single_ecc_error_hi_dc3) begin
                e.a = end_addr_dc3 & 16'hFFFC;
                e.d = store_ecc_datafn_hi_dc3;
                dc4q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        chk("wr_en", ecc_wr_en, e_wr_en);
        chk("gnt", stbuf_drain_gnt, e_gnt);
        chk("busy", ecc_wb_busy, e_busy);
        chk("ovf", ecc_wb_ovf, e_ovf);
        chk("addr", ecc_wr_addr, e_addr);
        chk("data", ecc_wr_data, e_data);
        chk("excl", ecc_wr_en & stbuf_drain_gnt, 1'b0);
`ifdef LSU_ECC_WB_CNT_EN
        chk("count", ecc_wb_count, e_cnt);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic idle_inputs();
        single_ecc_error_hi_dc3  = 1'b0;
        single_ecc_error_lo_dc3  = 1'b0;
        lsu_double_ecc_error_dc3 = 1'b0;
        dec_tlu_core_ecc_disable = 1'b0;
        flush_dc4                = 1'b0;
`ifdef LSU_ECC_WB_CNT_EN
        ecc_wb_count_clr         = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        stbuf_drain_req = 1'b0;
        rst_l = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    int gnt_cyc[$];
    bit started;
    int req_pct;

    initial begin
        rst_l        = 1'b0;
        lsu_addr_dc3 = '0;
        end_addr_dc3 = '0;
        store_ecc_datafn_hi_dc3 = '0;
        store_ecc_datafn_lo_dc3 = '0;
        stbuf_drain_req = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        cycle();

        // Lo SEC: write two cycles later, busy drops one cycle after that.
        single_ecc_error_lo_dc3 = 1'b1;
        lsu_addr_dc3            = 16'h0106;
        store_ecc_datafn_lo_dc3 = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        cycle();
        chk("t1_wr_en", ecc_wr_en, 1'b1);
        chk("t1_addr", ecc_wr_addr, 16'h0104);
        chk("t1_data", ecc_wr_data, 32'hDEADBEEF);
        chk("t1_busy_hi", ecc_wb_busy, 1'b1);
        cycle();
        chk("t1_busy_lo", ecc_wb_busy, 1'b0);
        chk("t1_wr_done", ecc_wr_en, 1'b0);
        chk("t1_addr_held", ecc_wr_addr, 16'h0104);

        // Hi+lo SEC: lo then hi on consecutive cycles.
        single_ecc_error_lo_dc3 = 1'b1;
        single_ecc_error_hi_dc3 = 1'b1;
        lsu_addr_dc3            = 16'h0206;
        end_addr_dc3            = 16'h0209;
        store_ecc_datafn_lo_dc3 = 32'h1111_AAAA;
        store_ecc_datafn_hi_dc3 = 32'h2222_BBBB;
        cycle();
        idle_inputs();
        cycle();
        chk("t2_lo_addr", ecc_wr_addr, 16'h0204);
        chk("t2_lo_data", ecc_wr_data, 32'h1111_AAAA);
        cycle();
        chk("t2_hi_en", ecc_wr_en, 1'b1);
        chk("t2_hi_addr", ecc_wr_addr, 16'h0208);
        chk("t2_hi_data", ecc_wr_data, 32'h2222_BBBB);
        cycle();
`ifdef LSU_ECC_WB_CNT_EN
        chk("cnt_three", ecc_wb_count, 16'd3);
        single_ecc_error_lo_dc3 = 1'b1;
        lsu_addr_dc3            = 16'h0300;
        cycle();
        idle_inputs();
        cycle();
        chk("cnt_wr_en", ecc_wr_en, 1'b1);
        ecc_wb_count_clr = 1'b1;
        cycle();
        ecc_wb_count_clr = 1'b0;
        chk("cnt_clr", ecc_wb_count, 16'd0);
        cycle();
`endif

        // Flushed SEC, then a DED-flagged SEC, then a disabled SEC: nothing written.
        single_ecc_error_lo_dc3 = 1'b1;
        lsu_addr_dc3            = 16'h0400;
        cycle();
        idle_inputs();
        flush_dc4 = 1'b1;
        cycle();
        flush_dc4                = 1'b0;
        single_ecc_error_lo_dc3  = 1'b1;
        lsu_double_ecc_error_dc3 = 1'b1;
        cycle();
        chk("t3_flush_no_wr", ecc_wr_en, 1'b0);
        lsu_double_ecc_error_dc3 = 1'b0;
        dec_tlu_core_ecc_disable = 1'b1;
        cycle();
        chk("t3_ded_no_wr", ecc_wr_en, 1'b0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_no_wr", ecc_wr_en, 1'b0);
        end
        chk("t3_empty", ecc_wb_busy, 1'b0);
        chk("t3_no_ovf", ecc_wb_ovf, 1'b0);

        // Overflow: stbuf request held, hi+lo SECs back to back fill the FIFO.
        stbuf_drain_req = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            single_ecc_error_lo_dc3 = 1'b1;
            single_ecc_error_hi_dc3 = 1'b1;
            lsu_addr_dc3            = 16'h0500 + 16'(i * 8);
            end_addr_dc3            = 16'h0504 + 16'(i * 8);
            store_ecc_datafn_lo_dc3 = 32'hA000_0000 + 32'(i);
            store_ecc_datafn_hi_dc3 = 32'hB000_0000 + 32'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        chk("t4_ovf_set", ecc_wb_ovf, 1'b1);
        for (int i = 0; i < 8; i++) cycle();
        chk("t4_ovf_sticky", ecc_wb_ovf, 1'b1);

        // Starvation: FIFO kept busy, stbuf wins every fifth cycle.
        started = 0;
        gnt_cyc.delete();
        for (int i = 0; i < 40; i++) begin
            single_ecc_error_lo_dc3 = 1'b1;
            single_ecc_error_hi_dc3 = 1'b1;
            lsu_addr_dc3            = 16'(i * 16);
            end_addr_dc3            = 16'(i * 16 + 4);
            store_ecc_datafn_lo_dc3 = $urandom;
            store_ecc_datafn_hi_dc3 = $urandom;
            cycle();
            if (ecc_wr_en) started = 1;
            if (started && stbuf_drain_gnt) gnt_cyc.push_back(cyc);
        end
        chk("t5_ngnt", (gnt_cyc.size() >= 6), 1'b1);
        for (int i = 1; i < gnt_cyc.size(); i++) begin
            chk("t5_gap", gnt_cyc[i] - gnt_cyc[i-1], 5);
        end

        // Reset while entries are queued discards them.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_no_wr", ecc_wr_en, 1'b0);
        end

        // Randomized traffic with varying stbuf pressure.
        for (int i = 0; i < 600; i++) begin
            case (i / 150)
                0:       req_pct = 0;
                1:       req_pct = 50;
                2:       req_pct = 90;
                default: req_pct = 100;
            endcase
            single_ecc_error_lo_dc3  = ($urandom_range(0, 99) < 35);
            single_ecc_error_hi_dc3  = ($urandom_range(0, 99) < 35);
            lsu_double_ecc_error_dc3 = ($urandom_range(0, 99) < 10);
            dec_tlu_core_ecc_disable = ($urandom_range(0, 99) < 10);
            flush_dc4                = ($urandom_range(0, 99) < 15);
            stbuf_drain_req          = ($urandom_range(0, 99) < req_pct);
            lsu_addr_dc3             = 16'($urandom);
            end_addr_dc3             = 16'($urandom);
            store_ecc_datafn_lo_dc3  = $urandom;
            store_ecc_datafn_hi_dc3  = $urandom;
`ifdef LSU_ECC_WB_CNT_EN
            ecc_wb_count_clr         = ($urandom_range(0, 99) < 5);
`endif
            cycle();
            if (i == 300) do_reset();
        end
        idle_inputs();
        stbuf_drain_req = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("end_idle", ecc_wb_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
